// File: rtl/pe_sequencer_pkg.sv
// pe_sequencer shared types and widths.
// FSM encoding, operand and result widths.
package pe_sequencer_pkg;

   localparam int OP_W  = 8;
   localparam int RES_W = 24;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRIME,
      S_STREAM,
      S_WAIT_DONE,
      S_HOLD
   } state_t;

endpackage

// File: rtl/seq_timer.sv
// seq_timer: wait-for-done timeout counter.
// Load sets the count to 1; expire when it reaches TIMEOUT.
module seq_timer #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic enable,
   output logic expire
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] r_cnt;

   assign expire = (r_cnt == CW'(TIMEOUT));

   // count up while enabled, saturating at the expiry value
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (load) begin
         r_cnt <= CW'(1);
      end else if (enable && !expire) begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/pe_sequencer.sv
// pe_sequencer: streams K operand pairs from a buffer into a PE
// and returns the PE result (or a timeout error) downstream.
module pe_sequencer
   import pe_sequencer_pkg::*;
#(
   parameter int ADDR_W  = 8,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] len,
   output logic              busy,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [OP_W-1:0]   rd_data1,
   input  logic [OP_W-1:0]   rd_data2,
   output logic              pe_ready,
   output logic [OP_W-1:0]   pe_data1,
   output logic [OP_W-1:0]   pe_data2,
   input  logic              pe_done,
   input  logic [RES_W-1:0]  pe_outdata,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [RES_W-1:0]  res_data,
   output logic              res_err
);

   state_t             r_state;
   state_t             w_next;
   logic [ADDR_W-1:0]  r_len;
   logic [ADDR_W-1:0]  r_idx;
   logic [RES_W-1:0]   r_res;
   logic               r_err;
   logic               w_last;
   logic               w_tload;
   logic               w_tenb;
   logic               w_expire;

   assign w_last   = (r_idx == r_len - ADDR_W'(1));
   assign res_data = r_res;
   assign res_err  = r_err;

   seq_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .load   (w_tload),
      .enable (w_tenb),
      .expire (w_expire)
   );

   // state register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // next state and per-state outputs
   always_comb begin
      w_next    = r_state;
      busy      = 1'b1;
      rd_en     = 1'b0;
      rd_addr   = '0;
      pe_ready  = 1'b0;
      pe_data1  = '0;
      pe_data2  = '0;
      res_valid = 1'b0;
      w_tload   = 1'b0;
      w_tenb    = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) begin
               w_next = (len != '0) ? S_PRIME : S_HOLD;
            end
         end
         S_PRIME: begin
            rd_en  = 1'b1;
            w_next = S_STREAM;
         end
         S_STREAM: begin
            pe_ready = 1'b1;
            pe_data1 = rd_data1;
            pe_data2 = rd_data2;
            rd_en    = !w_last;
            rd_addr  = w_last ? '0 : r_idx + ADDR_W'(1);
            if (pe_done) begin
               w_next = S_HOLD;
            end else if (w_last) begin
               w_next  = S_WAIT_DONE;
               w_tload = 1'b1;
            end
         end
         S_WAIT_DONE: begin
            pe_ready = 1'b1;
            w_tenb   = 1'b1;
            if (pe_done || w_expire) begin
               w_next = S_HOLD;
            end
         end
         S_HOLD: begin
            res_valid = 1'b1;
            if (res_ready) begin
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // job length, pair index and result capture
   always_ff @(posedge clk) begin
      if (rst) begin
         r_len <= '0;
         r_idx <= '0;
         r_res <= '0;
         r_err <= 1'b0;
      end else begin
         if (r_state == S_IDLE && start) begin
            r_len <= len;
            r_idx <= '0;
            if (len == '0) begin
               r_res <= '0;
               r_err <= 1'b0;
            end
         end
         if (r_state == S_STREAM) begin
            r_idx <= r_idx + ADDR_W'(1);
         end
         if ((r_state == S_STREAM || r_state == S_WAIT_DONE)
             && pe_done) begin
            r_res <= pe_outdata;
            r_err <= 1'b0;
         end else if (r_state == S_WAIT_DONE && w_expire) begin
            r_res <= '0;
            r_err <= 1'b1;
         end
      end
   end

endmodule
